sram_burst_controller: RTL and testbench

- Parametrised asynchronous-SRAM controller for the 16-bit external SRAM (CE/OE/WE/LB/UB pins).
- Serves one CPU-side request of WORDS consecutive 16-bit SRAM words (e.g. one 32-bit bus word) per handshake.
- Setup, strobe and hold timing are programmable per phase; writes carry per-byte enables.
- Sits between the system bus bridge and the SRAM pins; replaces the fixed-timing single-word SRAM interface.

---
 rtl/sram_burst_controller_if.sv | 23 ++
 rtl/sram_burst_controller.sv | 154 +++++++++++++++
 tb/tb_sram_burst_controller.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_controller_if.sv
// CPU-side request/response bundle of the SRAM burst controller.
interface sram_burst_controller_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned WORDS  = 2
);
    logic                  i_enable;
    logic                  i_rw;
    logic [ADDR_W-1:0]     i_address;
    logic [2*WORDS-1:0]    i_byte_en;
    logic [16*WORDS-1:0]   i_wdata;
    logic [16*WORDS-1:0]   o_rdata;
    logic                  o_ready;

    modport master (
        output i_enable, i_rw, i_address, i_byte_en, i_wdata,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_enable, i_rw, i_address, i_byte_en, i_wdata,
        output o_rdata, o_ready
    );
endinterface

// File: rtl/sram_burst_controller.sv
// Asynchronous 16-bit SRAM controller: one request moves WORDS consecutive words
// with programmable setup/strobe/hold phases; every SRAM pin is driven from a flop.
module sram_burst_controller #(
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned WORDS         = 2,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned ACCESS_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    sram_burst_controller_if.slave  bus,
    output logic [ADDR_W-1:0]       SRAM_A,
    inout  wire  [15:0]             SRAM_D,
    output logic                    SRAM_CE_n,
    output logic                    SRAM_OE_n,
    output logic                    SRAM_WE_n,
    output logic                    SRAM_LB_n,
    output logic                    SRAM_UB_n
);
    localparam int unsigned KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned MAX_C = (SETUP_CYCLES > ACCESS_CYCLES)
                                  ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                                  : ((ACCESS_CYCLES > HOLD_CYCLES) ? ACCESS_CYCLES : HOLD_CYCLES);
    localparam int unsigned CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_e;

    state_e            state_q;
    logic [KW-1:0]     k_q;
    logic [KW-1:0]     k_nxt;
    logic [CW-1:0]     cnt_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        be_q [WORDS];
    logic [15:0]       wd_q [WORDS];
    logic [15:0]       rd_q [WORDS];
    logic [15:0]       dout_q;
    logic              drive_q;

    assign k_nxt       = k_q + KW'(1);
    assign SRAM_D      = drive_q ? dout_q : 16'hzzzz;
    assign bus.o_ready = (state_q == DONE) && bus.i_enable;

    for (genvar w = 0; w < WORDS; w++) begin : g_rdata
        assign bus.o_rdata[16*w +: 16] = rd_q[w];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            drive_q   <= 1'b0;
            SRAM_A    <= '0;
            SRAM_CE_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
            SRAM_WE_n <= 1'b1;
            SRAM_LB_n <= 1'b1;
            SRAM_UB_n <= 1'b1;
            for (int w = 0; w < WORDS; w++) begin
                be_q[w] <= '0;
                wd_q[w] <= '0;
                rd_q[w] <= '0;
            end
        end else if ((state_q == SETUP || state_q == ACCESS || state_q == HOLD) && !bus.i_enable) begin
            // Abort: release the bus and raise every strobe, keep captured read words
            state_q   <= IDLE;
            drive_q   <= 1'b0;
            SRAM_CE_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
            SRAM_WE_n <= 1'b1;
            SRAM_LB_n <= 1'b1;
            SRAM_UB_n <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_enable) begin
                        state_q   <= SETUP;
                        k_q       <= '0;
                        cnt_q     <= CW'(SETUP_CYCLES - 1);
                        rw_q      <= bus.i_rw;
                        addr_q    <= bus.i_address;
                        for (int w = 0; w < WORDS; w++) begin
                            be_q[w] <= bus.i_byte_en[2*w +: 2];
                            wd_q[w] <= bus.i_wdata[16*w +: 16];
                        end
                        SRAM_A    <= bus.i_address;
                        SRAM_CE_n <= 1'b0;
                        SRAM_OE_n <= 1'b1;
                        SRAM_WE_n <= 1'b1;
                        SRAM_LB_n <= bus.i_rw & ~bus.i_byte_en[0];
                        SRAM_UB_n <= bus.i_rw & ~bus.i_byte_en[1];
                        dout_q    <= bus.i_wdata[15:0];
                        drive_q   <= bus.i_rw;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q   <= ACCESS;
                        cnt_q     <= CW'(ACCESS_CYCLES - 1);
                        SRAM_OE_n <= rw_q;
                        SRAM_WE_n <= ~rw_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q   <= HOLD;
                        cnt_q     <= CW'(HOLD_CYCLES - 1);
                        SRAM_OE_n <= 1'b1;
                        SRAM_WE_n <= 1'b1;
                        SRAM_CE_n <= 1'b1;
                        if (!rw_q) begin
                            rd_q[k_q] <= SRAM_D;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (k_q == KW'(WORDS - 1)) begin
                        state_q   <= DONE;
                        drive_q   <= 1'b0;
                        SRAM_LB_n <= 1'b1;
                        SRAM_UB_n <= 1'b1;
                    end else begin
                        // Next word: new address and lanes presented at the start of its setup
                        state_q   <= SETUP;
                        k_q       <= k_nxt;
                        cnt_q     <= CW'(SETUP_CYCLES - 1);
                        SRAM_A    <= addr_q + ADDR_W'(k_nxt);
                        SRAM_CE_n <= 1'b0;
                        SRAM_LB_n <= rw_q & ~be_q[k_nxt][0];
                        SRAM_UB_n <= rw_q & ~be_q[k_nxt][1];
                        dout_q    <= wd_q[k_nxt];
                    end
                end
                DONE: begin
                    if (!bus.i_enable) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_burst_controller.sv
// Self-checking bench: behavioural SRAM on the pins plus a word-level reference memory.
module tb_sram_burst_controller;
    logic clk;
    logic rst;

    sram_burst_controller_if #(.ADDR_W(18), .WORDS(2)) bus1 ();
    sram_burst_controller_if #(.ADDR_W(18), .WORDS(1)) bus2 ();

    logic [17:0] p_a;
    wire  [15:0] p_d;
    logic        p_ce, p_oe, p_we, p_lb, p_ub;
    logic [17:0] q_a;
    wire  [15:0] q_d;
    logic        q_ce, q_oe, q_we, q_lb, q_ub;

    logic [15:0] mem [0:262143];
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rd;
    int n_cmp;
    int n_bad;

    sram_burst_controller dut (
        .i_clock(clk), .i_reset(rst), .bus(bus1.slave),
        .SRAM_A(p_a), .SRAM_D(p_d), .SRAM_CE_n(p_ce), .SRAM_OE_n(p_oe),
        .SRAM_WE_n(p_we), .SRAM_LB_n(p_lb), .SRAM_UB_n(p_ub)
    );

    sram_burst_controller #(
        .ADDR_W(18), .WORDS(1), .SETUP_CYCLES(1), .ACCESS_CYCLES(1), .HOLD_CYCLES(1)
    ) dut_b2b (
        .i_clock(clk), .i_reset(rst), .bus(bus2.slave),
        .SRAM_A(q_a), .SRAM_D(q_d), .SRAM_CE_n(q_ce), .SRAM_OE_n(q_oe),
        .SRAM_WE_n(q_we), .SRAM_LB_n(q_lb), .SRAM_UB_n(q_ub)
    );

    // Asynchronous SRAM read path: drives the selected lanes while output-enabled
    assign p_d = (!p_ce && !p_oe && p_we)
               ? {(p_ub ? 8'hzz : mem[p_a][15:8]), (p_lb ? 8'hzz : mem[p_a][7:0])}
               : 16'hzzzz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next falling edge, applying any SRAM write in progress
    task automatic tick();
        @(negedge clk);
        if (!p_ce && !p_we) begin
            if (!p_lb) mem[p_a][7:0]  = p_d[7:0];
            if (!p_ub) mem[p_a][15:8] = p_d[15:8];
        end
    endtask

    function automatic bit bus_free(input logic [15:0] d);
        return (d === 16'hzzzz) || (d === 16'h0000);
    endfunction

    task automatic preload(input logic [17:0] a, input logic [15:0] v);
        mem[a] = v;
        ref_mem[int'(a)] = v;
    endtask

    function automatic logic [31:0] ref_read(input logic [17:0] a);
        logic [17:0] an;
        an = a + 18'd1;
        return {ref_mem[int'(an)], ref_mem[int'(a)]};
    endfunction

    task automatic ref_write(input logic [17:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [17:0] ak;
        logic [15:0] v;
        for (int k = 0; k < 2; k++) begin
            ak = a + 18'(k);
            v  = ref_mem[int'(ak)];
            if (be[2*k])   v[7:0]  = wd[16*k +: 8];
            if (be[2*k+1]) v[15:8] = wd[16*k+8 +: 8];
            ref_mem[int'(ak)] = v;
        end
    endtask

    // One request on the default controller; abort_at >= 0 drops i_enable at that cycle
    task automatic run_txn(input logic rw, input logic [17:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int abort_at,
                           output int lat, output int oe_low, output int drv,
                           output logic [17:0] fa, output logic [17:0] sa, output logic [1:0] lbub_w);
        bit seen;
        lat = -1; oe_low = 0; drv = 0; fa = '0; sa = '0; lbub_w = 2'b00; seen = 0;
        bus1.i_enable = 1'b1; bus1.i_rw = rw; bus1.i_address = addr;
        bus1.i_byte_en = be; bus1.i_wdata = wd;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (n == 0) begin
                bus1.i_rw = ~rw; bus1.i_address = 18'($urandom);
                bus1.i_byte_en = 4'($urandom); bus1.i_wdata = $urandom;
            end
            if (bus1.o_ready) begin
                lat = n;
                break;
            end
            if (!p_ce) begin
                if (!seen) begin fa = p_a; sa = p_a; seen = 1; end
                else if (p_a != fa) sa = p_a;
            end
            if (!p_oe) oe_low++;
            if (!rw && p_oe && !bus_free(p_d)) drv++;
            if (!p_we) lbub_w = {p_ub, p_lb};
            if (n == abort_at) begin
                bus1.i_enable = 1'b0;
                break;
            end
        end
        if (abort_at < 0) begin
            bus1.i_enable = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if ({p_ce, p_oe, p_we, p_lb, p_ub} !== 5'b11111) begin n_bad++; $display("FAIL reset_strobes: got %b want 11111", {p_ce, p_oe, p_we, p_lb, p_ub}); end
        n_cmp++; if (p_a !== 18'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00000", p_a); end
        n_cmp++; if (bus1.o_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus1.o_rdata); end
        n_cmp++; if (bus1.o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus1.o_ready); end
        n_cmp++; if (!bus_free(p_d)) begin n_bad++; $display("FAIL reset_bus: got %h want released", p_d); end
        n_cmp++; if (q_ce !== 1'b1) begin n_bad++; $display("FAIL reset_b2b_ce: got %b want 1", q_ce); end
        rst = 1'b0;
        tick();
        exp_rd = 32'h0;
    endtask

    task automatic test_read();
        int lat, oe_low, drv;
        logic [17:0] fa, sa;
        logic [1:0] lu;
        preload(18'h00010, 16'h1234);
        preload(18'h00011, 16'hABCD);
        run_txn(1'b0, 18'h00010, 4'b0000, 32'h5A5A_A5A5, -1, lat, oe_low, drv, fa, sa, lu);
        exp_rd = ref_read(18'h00010);
        n_cmp++; if (bus1.o_rdata !== 32'hABCD1234) begin n_bad++; $display("FAIL read_data: got %h want abcd1234", bus1.o_rdata); end
        n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL read_latency: got %0d want 12", lat); end
        n_cmp++; if (oe_low != 6) begin n_bad++; $display("FAIL read_oe_cycles: got %0d want 6", oe_low); end
        n_cmp++; if (drv != 0) begin n_bad++; $display("FAIL read_bus_driven: got %0d want 0", drv); end
        n_cmp++; if (fa !== 18'h10 || sa !== 18'h11) begin n_bad++; $display("FAIL read_addrs: got %h,%h want 00010,00011", fa, sa); end
    endtask

    task automatic test_write_be();
        int lat, oe_low, drv;
        logic [17:0] fa, sa;
        logic [1:0] lu;
        preload(18'h00020, 16'hFFFF);
        preload(18'h00021, 16'hFFFF);
        // Word 0 fully written, word 1 only its high byte
        run_txn(1'b1, 18'h00020, 4'b1011, 32'hCAFE_BEEF, -1, lat, oe_low, drv, fa, sa, lu);
        ref_write(18'h00020, 4'b1011, 32'hCAFE_BEEF);
        n_cmp++; if (mem[18'h20] !== 16'hBEEF) begin n_bad++; $display("FAIL write_word0: got %h want beef", mem[18'h20]); end
        n_cmp++; if (mem[18'h21] !== 16'hCAFF) begin n_bad++; $display("FAIL write_word1: got %h want caff", mem[18'h21]); end
        n_cmp++; if (lu !== 2'b01) begin n_bad++; $display("FAIL write_lanes_word1: got ub/lb %b want 01", lu); end
        n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL write_latency: got %0d want 12", lat); end
        n_cmp++; if (oe_low != 0) begin n_bad++; $display("FAIL write_oe: got %0d want 0", oe_low); end
        n_cmp++; if (bus1.o_rdata !== exp_rd) begin n_bad++; $display("FAIL write_keeps_rdata: got %h want %h", bus1.o_rdata, exp_rd); end
    endtask

    task automatic test_wrap();
        int lat, oe_low, drv;
        logic [17:0] fa, sa;
        logic [1:0] lu;
        preload(18'h3FFFF, 16'($urandom));
        preload(18'h00000, 16'($urandom));
        run_txn(1'b0, 18'h3FFFF, 4'b0000, 32'h1357_9BDF, -1, lat, oe_low, drv, fa, sa, lu);
        exp_rd = ref_read(18'h3FFFF);
        n_cmp++; if (fa !== 18'h3FFFF || sa !== 18'h00000) begin n_bad++; $display("FAIL wrap_addrs: got %h,%h want 3ffff,00000", fa, sa); end
        n_cmp++; if (bus1.o_rdata !== exp_rd) begin n_bad++; $display("FAIL wrap_data: got %h want %h", bus1.o_rdata, exp_rd); end
    endtask

    task automatic test_abort();
        int lat, oe_low, drv;
        logic [17:0] fa, sa;
        logic [1:0] lu;
        bit rdy_seen;
        preload(18'h00040, 16'h0F1E);
        preload(18'h00041, 16'h2D3C);
        // Cycle 9 is in the second word's strobe phase
        run_txn(1'b0, 18'h00040, 4'b0000, 32'h6789_4321, 9, lat, oe_low, drv, fa, sa, lu);
        exp_rd = {exp_rd[31:16], ref_mem[32'h40]};
        rdy_seen = (lat >= 0);
        tick();
        n_cmp++; if (p_ce !== 1'b1 || p_oe !== 1'b1) begin n_bad++; $display("FAIL abort_strobes: got ce=%b oe=%b want 1,1", p_ce, p_oe); end
        n_cmp++; if (bus1.o_rdata !== exp_rd) begin n_bad++; $display("FAIL abort_rdata: got %h want %h", bus1.o_rdata, exp_rd); end
        for (int i = 0; i < 3; i++) begin
            if (bus1.o_ready) rdy_seen = 1;
            tick();
        end
        n_cmp++; if (rdy_seen) begin n_bad++; $display("FAIL abort_ready: got 1 want 0"); end
        n_cmp++; if (p_ce !== 1'b1) begin n_bad++; $display("FAIL abort_idle_ce: got %b want 1", p_ce); end
    endtask

    task automatic test_reset_mid_write();
        preload(18'h00030, 16'hFFFF);
        preload(18'h00031, 16'hFFFF);
        bus1.i_enable = 1'b1; bus1.i_rw = 1'b1; bus1.i_address = 18'h00030;
        bus1.i_byte_en = 4'b1111; bus1.i_wdata = 32'h9876_5432;
        for (int n = 0; n < 4; n++) tick();
        n_cmp++; if (p_we !== 1'b0) begin n_bad++; $display("FAIL rstw_in_access: got we=%b want 0", p_we); end
        rst = 1'b1; bus1.i_enable = 1'b0;
        tick();
        n_cmp++; if (p_we !== 1'b1 || p_ce !== 1'b1) begin n_bad++; $display("FAIL rstw_strobes: got we=%b ce=%b want 1,1", p_we, p_ce); end
        n_cmp++; if (!bus_free(p_d)) begin n_bad++; $display("FAIL rstw_bus: got %h want released", p_d); end
        n_cmp++; if (bus1.o_rdata !== 32'h0) begin n_bad++; $display("FAIL rstw_rdata: got %h want 0", bus1.o_rdata); end
        rst = 1'b0;
        tick(); tick();
        n_cmp++; if (p_ce !== 1'b1) begin n_bad++; $display("FAIL rstw_idle: got ce=%b want 1", p_ce); end
        exp_rd = 32'h0;
        ref_mem[32'h30] = mem[18'h30];
        ref_mem[32'h31] = mem[18'h31];
    endtask

    task automatic test_random();
        int lat, oe_low, drv;
        logic [17:0] fa, sa, a;
        logic [1:0] lu;
        logic rw;
        logic [3:0] be;
        logic [31:0] wd;
        for (int w = 'h100; w <= 'h110; w++) preload(18'(w), 16'($urandom));
        preload(18'h3FFFF, 16'($urandom));
        preload(18'h00000, 16'($urandom));
        for (int t = 0; t < 24; t++) begin
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 4) == 0) ? 18'h3FFFF : 18'h100 + 18'($urandom_range(0, 14));
            be = 4'($urandom);
            wd = $urandom | 32'h0001_0001;
            run_txn(rw, a, be, wd, -1, lat, oe_low, drv, fa, sa, lu);
            n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want 12", t, lat); end
            if (rw) begin
                ref_write(a, be, wd);
                n_cmp++; if (bus1.o_rdata !== exp_rd) begin n_bad++; $display("FAIL rand_wr_rdata[%0d]: got %h want %h", t, bus1.o_rdata, exp_rd); end
            end else begin
                exp_rd = ref_read(a);
                n_cmp++; if (bus1.o_rdata !== exp_rd) begin n_bad++; $display("FAIL rand_rd_data[%0d]: got %h want %h", t, bus1.o_rdata, exp_rd); end
                n_cmp++; if (drv != 0) begin n_bad++; $display("FAIL rand_rd_bus[%0d]: got %0d want 0", t, drv); end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int w = 'h100; w <= 'h110; w++) begin
            n_cmp++; if (mem[18'(w)] !== ref_mem[w]) begin n_bad++; $display("FAIL rand_mem[%h]: got %h want %h", w, mem[18'(w)], ref_mem[w]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, hi;
        bit early;
        lat = -1; hi = 0; early = 0;
        bus2.i_enable = 1'b1; bus2.i_rw = 1'b0; bus2.i_address = 18'($urandom);
        bus2.i_byte_en = 2'b11; bus2.i_wdata = 16'h0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus2.o_ready) begin lat = n; break; end
        end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL b2b_latency: got %0d want 3", lat); end
        if (bus2.o_ready) hi++;
        tick(); if (bus2.o_ready) hi++;
        tick(); if (bus2.o_ready) hi++;
        bus2.i_enable = 1'b0;
        tick();
        if (bus2.o_ready) early = 1;
        n_cmp++; if (q_ce !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_idle: got ce=%b want 1", q_ce); end
        bus2.i_enable = 1'b1;
        tick();
        if (bus2.o_ready) early = 1;
        n_cmp++; if (hi != 3) begin n_bad++; $display("FAIL b2b_ready_cycles: got %0d want 3", hi); end
        n_cmp++; if (early) begin n_bad++; $display("FAIL b2b_ready_gap: got 1 want 0"); end
        n_cmp++; if (q_ce !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept: got ce=%b want 0", q_ce); end
        lat = -1;
        for (int n = 1; n < 20; n++) begin
            tick();
            if (bus2.o_ready) begin lat = n; break; end
        end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 3", lat); end
        bus2.i_enable = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_rd = '0; rst = 1'b1;
        bus1.i_enable = 1'b0; bus1.i_rw = 1'b0; bus1.i_address = '0;
        bus1.i_byte_en = '0; bus1.i_wdata = '0;
        bus2.i_enable = 1'b0; bus2.i_rw = 1'b0; bus2.i_address = '0;
        bus2.i_byte_en = '0; bus2.i_wdata = '0;
        test_reset();
        test_read();
        test_write_be();
        test_wrap();
        test_abort();
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
